// File: rtl/calc_pkg.sv
// calc_pkg: shared constants and types for the calculator sequencer.
//   INSTR_W  instruction word width {op, a, b}
//   *_MSB/*_LSB  field positions within an instruction word
//   state_t  run-controller states
package calc_pkg;
  localparam int OP_W    = 2;
  localparam int OPND_W  = 8;
  localparam int INSTR_W = OP_W + 2*OPND_W;   // 18
  localparam int OP_MSB  = 17;
  localparam int OP_LSB  = 16;
  localparam int A_MSB   = 15;
  localparam int A_LSB   = 8;
  localparam int B_MSB   = 7;
  localparam int B_LSB   = 0;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, WAIT_OUT} state_t;
endpackage

// File: rtl/calc_if.sv
// calc_if: instruction-in and result-out valid/ready handshakes.
//   in_valid/in_ready/in_data     instruction words {op, a, b}
//   res_valid/res_ready/res_data/res_neg  captured ALU results
//   slave  : sequencer side (consumes instructions, produces results)
//   master : environment side
interface calc_if #(
  parameter int OPW  = 8,
  parameter int RESW = 16
);
  import calc_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [OP_W+2*OPW-1:0] in_data;
  logic                  res_valid;
  logic                  res_ready;
  logic [RESW-1:0]       res_data;
  logic                  res_neg;

  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_data, res_neg
  );

  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_data, res_neg
  );
endinterface

// File: rtl/calc_instr_buf.sv
// calc_instr_buf: DEPTH x W instruction register file.
//   clk      write clock
//   wr_en    write strobe; wr_addr/wr_data written on posedge
//   rd_addr  asynchronous read address, rd_data combinational
// Storage is not reset: contents are only meaningful below the
// sequencer's count, which is reset.
module calc_instr_buf #(
  parameter int DEPTH = 16,
  parameter int W     = 18,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: buffers instruction words and runs them through an
// external combinational ALU, one result every three cycles.
//   clk, reset           clock, async active-high reset
//   bus (calc_if.slave)  instruction input and result output handshakes
//   start                pulse: run buffered words (same-cycle write included)
//   flush                clear buffer in IDLE when start is low
//   alu_op/alu_a/alu_b   registered operands to the ALU
//   alu_result/alu_neg   ALU outputs, captured one cycle after issue
//   busy                 not IDLE
//   done                 one-cycle pulse after the last result is accepted
//   count                buffered word count (0..DEPTH)
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int OPW   = 8,
  parameter int RESW  = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  calc_if.slave           bus,
  input  logic            start,
  input  logic            flush,
  output logic [OP_W-1:0] alu_op,
  output logic [OPW-1:0]  alu_a,
  output logic [OPW-1:0]  alu_b,
  input  logic [RESW-1:0] alu_result,
  input  logic            alu_neg,
  output logic            busy,
  output logic            done,
  output logic [AW:0]     count
);
  localparam int IW = OP_W + 2*OPW;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [IW-1:0] rd_word;
  logic          idle, wr_en, do_flush, go, hs, is_last;
  logic [AW:0]   post_cnt;

  assign idle         = (state_q == IDLE);
  assign busy         = ~idle;
  assign bus.in_ready = idle && (count < (AW+1)'(DEPTH));
  // start takes priority over flush; a flush drops any same-cycle write
  assign do_flush     = idle && flush && !start;
  assign wr_en        = bus.in_valid && bus.in_ready && !do_flush;
  assign post_cnt     = count + {{AW{1'b0}}, wr_en};
  assign go           = idle && start && (post_cnt != '0);
  assign hs           = (state_q == WAIT_OUT) && bus.res_ready;
  assign is_last      = ({1'b0, rd_ptr} == count - 1'b1);

  calc_instr_buf #(.DEPTH(DEPTH), .W(IW)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (bus.in_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_word)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (go) state_d = ISSUE;
      ISSUE:    state_d = CAPTURE;
      CAPTURE:  state_d = WAIT_OUT;
      WAIT_OUT: if (hs) state_d = is_last ? IDLE : ISSUE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      alu_op        <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      bus.res_data  <= '0;
      bus.res_neg   <= 1'b0;
      bus.res_valid <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (do_flush) begin
            wr_ptr <= '0;
            count  <= '0;
          end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            count <= post_cnt;
          end
          if (go) rd_ptr <= '0;
        end
        ISSUE: begin
          alu_op <= rd_word[IW-1 -: OP_W];
          alu_a  <= rd_word[2*OPW-1 -: OPW];
          alu_b  <= rd_word[OPW-1:0];
        end
        CAPTURE: begin
          bus.res_data  <= alu_result;
          bus.res_neg   <= alu_neg;
          bus.res_valid <= 1'b1;
        end
        WAIT_OUT: begin
          if (hs) begin
            bus.res_valid <= 1'b0;
            if (is_last) begin
              done   <= 1'b1;
              count  <= '0;
              wr_ptr <= '0;
              rd_ptr <= '0;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: scoreboard bench for calc_sequencer with an a*b ALU stub.
module tb_calc_sequencer;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  alu_op;
  logic [7:0]  alu_a, alu_b;
  logic [15:0] alu_result;
  logic        alu_neg;
  logic        busy, done;
  logic [4:0]  count;

  calc_if #(.OPW(8), .RESW(16)) bus ();

  calc_sequencer #(.DEPTH(16), .OPW(8), .RESW(16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .start(start), .flush(flush),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_neg(alu_neg),
    .busy(busy), .done(done), .count(count)
  );

  assign alu_result = {8'h00, alu_a} * {8'h00, alu_b};
  assign alu_neg    = (alu_op == 2'b01);

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_acc = 0;
  int done_cnt = 0;
  logic [16:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] exp_of(input logic [17:0] w);
    logic [15:0] p;
    p = {8'h00, w[A_MSB:A_LSB]} * {8'h00, w[B_MSB:B_LSB]};
    return {p, w[OP_MSB:OP_LSB] == 2'b01};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // result monitor: compare every accepted result against the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) chk("sb_extra_result", 32'd1, 32'd0);
        else chk("result", {15'd0, bus.res_data, bus.res_neg}, {15'd0, exp_q.pop_front()});
        last_acc = cyc;
      end
      if (done) begin
        done_cnt++;
        chk("done_lat", cyc, last_acc + 1);
        chk("done_count0", {27'd0, count}, 32'd0);
      end
    end
  end

  task automatic send(input logic [17:0] w);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(exp_of(w));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (done) begin
        @(posedge clk); #1;
        return;
      end
    end
    chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int d0;
    logic [15:0] snap_d;
    logic        snap_n;
    int k, hold;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.res_ready = 1'b0;

    // reset state
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_res_valid", {31'd0, bus.res_valid}, 0);
    chk("rst_count", {27'd0, count}, 0);
    chk("rst_alu", {14'd0, alu_op, alu_a, alu_b}, 0);
    chk("rst_res_data", {15'd0, bus.res_data, bus.res_neg}, 0);
    chk("rst_done", {31'd0, done}, 0);
    idle_cycles(3);
    reset = 1'b0;
    idle_cycles(1);

    // 1: three words, latency and done
    bus.res_ready = 1'b1;
    send({2'b00, 8'h03, 8'h04});
    send({2'b01, 8'h05, 8'h06});
    send({2'b10, 8'hFF, 8'hFF});
    chk("t1_count", {27'd0, count}, 3);
    chk("t1_exp_check", {15'd0, exp_q[2]}, {15'd0, 16'd65025, 1'b0});
    d0 = done_cnt;
    pulse_start();
    chk("t1_busy", {31'd0, busy}, 1);
    chk("t1_lat_n0", {31'd0, bus.res_valid}, 0);
    idle_cycles(1);
    chk("t1_lat_n1", {31'd0, bus.res_valid}, 0);
    idle_cycles(1);
    chk("t1_lat_n2", {31'd0, bus.res_valid}, 1);
    wait_done();
    chk("t1_done_once", done_cnt - d0, 1);
    chk("t1_sb_empty", exp_q.size(), 0);
    chk("t1_idle", {31'd0, busy}, 0);

    // 2: full buffer
    for (int i = 0; i < 16; i++)
      send({2'($urandom_range(3)), 8'($urandom), 8'($urandom)});
    chk("t2_count16", {27'd0, count}, 16);
    chk("t2_in_ready0", {31'd0, bus.in_ready}, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 18'h3ABCD;
    idle_cycles(3);
    bus.in_valid = 1'b0;
    chk("t2_no_17th", {27'd0, count}, 16);
    d0 = done_cnt;
    pulse_start();
    wait_done();
    idle_cycles(3);
    chk("t2_done_once", done_cnt - d0, 1);
    chk("t2_sb_empty", exp_q.size(), 0);

    // 3: backpressure on result 2
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send({2'(i), 8'($urandom), 8'($urandom)});
    d0 = done_cnt;
    pulse_start();
    k = 0; hold = 0;
    for (int t = 0; t < 200 && k < 4; t++) begin
      @(posedge clk); #1;
      if (bus.res_ready) begin
        bus.res_ready = 1'b0;
        k++;
      end else if (bus.res_valid) begin
        if (k == 1 && hold < 5) begin
          if (hold == 0) begin snap_d = bus.res_data; snap_n = bus.res_neg; end
          chk("t3_hold", {15'd0, bus.res_valid, bus.res_data, bus.res_neg},
              {15'd0, 1'b1, snap_d, snap_n});
          hold++;
        end else begin
          bus.res_ready = 1'b1;
        end
      end
    end
    chk("t3_all_accepted", k, 4);
    bus.res_ready = 1'b1;
    wait_done();
    chk("t3_done_once", done_cnt - d0, 1);
    chk("t3_sb_empty", exp_q.size(), 0);

    // 4: empty start ignored; write + start same cycle runs one word
    d0 = done_cnt;
    pulse_start();
    chk("t4_empty_busy", {31'd0, busy}, 0);
    idle_cycles(4);
    chk("t4_empty_busy2", {31'd0, busy}, 0);
    chk("t4_no_done", done_cnt - d0, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = {2'b01, 8'h07, 8'h09};
    start = 1'b1;
    exp_q.push_back(exp_of(bus.in_data));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    start = 1'b0;
    chk("t4_run1_busy", {31'd0, busy}, 1);
    wait_done();
    chk("t4_done_once", done_cnt - d0, 1);
    chk("t4_sb_empty", exp_q.size(), 0);

    // 5: flush in idle, flush while busy
    for (int i = 0; i < 5; i++)
      send({2'b00, 8'(i + 1), 8'h02});
    chk("t5_count5", {27'd0, count}, 5);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 18'h01111;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    chk("t5_flushed", {27'd0, count}, 0);
    d0 = done_cnt;
    pulse_start();
    idle_cycles(3);
    chk("t5_start_ignored", {31'd0, busy}, 0);
    chk("t5_no_done", done_cnt - d0, 0);
    send({2'b01, 8'h10, 8'h10});
    send({2'b11, 8'h80, 8'h02});
    bus.res_ready = 1'b0;
    pulse_start();
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 18'h02222;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("t5_busy_flush_count", {27'd0, count}, 2);
    chk("t5_busy_flush_busy", {31'd0, busy}, 1);
    bus.res_ready = 1'b1;
    wait_done();
    chk("t5_done_once", done_cnt - d0, 1);
    chk("t5_sb_empty", exp_q.size(), 0);

    // 6: reset during WAIT_OUT of result 1
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send({2'b10, 8'(i + 3), 8'h11});
    d0 = done_cnt;
    pulse_start();
    k = 0;
    for (int t = 0; t < 20 && !bus.res_valid; t++) begin
      @(posedge clk); #1;
      k++;
    end
    chk("t6_reached_wait", {31'd0, bus.res_valid}, 1);
    reset = 1'b1;
    #1;
    exp_q.delete();
    chk("t6_rst_res_valid", {31'd0, bus.res_valid}, 0);
    chk("t6_rst_busy", {31'd0, busy}, 0);
    chk("t6_rst_count", {27'd0, count}, 0);
    chk("t6_rst_alu", {14'd0, alu_op, alu_a, alu_b}, 0);
    chk("t6_rst_res", {15'd0, bus.res_data, bus.res_neg}, 0);
    chk("t6_rst_done", {31'd0, done}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycles(3);
    chk("t6_no_done", done_cnt - d0, 0);
    bus.res_ready = 1'b1;
    send({2'b01, 8'h0C, 8'h0D});
    send({2'b00, 8'hFF, 8'h01});
    pulse_start();
    wait_done();
    chk("t6_rerun_done", done_cnt - d0, 1);
    chk("t6_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
